// File: rtl/wishbone_arbiter.sv
// ============================================================================
// wishbone_arbiter : two-master / one-slave Wishbone classic round-robin arbiter
// Optional slave-hang watchdog compiled in with `define WB_ARB_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module wishbone_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wishbone_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2, ABORT = 2'd3} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic [1:0]  err_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;
`endif

  state_t     state_q;
  logic       last_owner_q;
  logic [1:0] gnt_q;
  logic       own_cyc;

  assign own_cyc = gnt_q[1] ? m1_cyc_i : m0_cyc_i;
  assign gnt_o   = gnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q        <= 16'd0;
      err_q        <= 2'b00;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err_q <= 2'b00;
`endif
      case (state_q)
        IDLE: begin
          // On a tie, the master that did not own the bus last goes first.
          if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
            state_q <= GRANT0;
            gnt_q   <= 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
          end else if (m1_cyc_i) begin
            state_q <= GRANT1;
            gnt_q   <= 2'b10;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
          end
        end
        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            last_owner_q <= gnt_q[1];
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (s_ack_i) begin
            cnt_q <= 16'd0;
          end else if (s_stb_o) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == TO_LAST) begin
              state_q <= ABORT;
              err_q   <= gnt_q;
            end
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!own_cyc) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            last_owner_q <= gnt_q[1];
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // Bus routing follows the registered state; ack is only forwarded while the owner holds cyc.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_data_o = '0;
    case (state_q)
      GRANT0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        m0_ack_o  = s_ack_i & m0_cyc_i;
        m0_data_o = s_data_i;
      end
      GRANT1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        m1_ack_o  = s_ack_i & m1_cyc_i;
        m1_data_o = s_data_i;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
// ============================================================================
// tb_wishbone_arbiter : vector table plus scoreboard sequences for wishbone_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wishbone_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [63:0] D0 = 64'hA0A0_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'hB1B1_1111_1111_11B1;
  localparam logic [63:0] SD = 64'h1122_3344_5566_7788;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [63:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]  gnt_o;

  wishbone_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // in:  {rst, m0c, m0s, m0w, m1c, m1s, m1w, ack}
  // ex:  {m0_ack, m1_ack, m0_err, abort}
  typedef struct {
    logic [7:0] in;
    logic [1:0] gnt;
    logic [3:0] ex;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [63:0] rd_sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void add(input logic [7:0] in, input logic [1:0] gnt, input logic [3:0] ex);
    vec_t v;
    v.in = in; v.gnt = gnt; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xact(input logic [63:0] d, input int dly);
    int  n;
    bit  got;
    @(negedge clk_i);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    rd_sb.push_back(d);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk_i); #1;
      got = gnt_o[0];
      n++;
    end
    chk("xact grant", {63'd0, got}, 64'd1);
    repeat (dly) @(negedge clk_i);
    s_ack_i = 1'b1; s_data_i = d;
    #1;
    chk("xact m0_ack", {63'd0, m0_ack_o}, 64'd1);
    chk("xact m1_ack", {63'd0, m1_ack_o}, 64'd0);
    chk("xact m0_data", m0_data_o, rd_sb.pop_front());
    @(negedge clk_i);
    s_ack_i = 1'b0; s_data_i = SD;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t  e;
    logic  own0, own1;
    string r;

    // Single master read, slave acks two cycles after the grant.
    add(8'b0_000_000_0, 2'b00, 4'b0000);
    add(8'b0_110_000_0, 2'b00, 4'b0000);
    add(8'b0_110_000_0, 2'b01, 4'b0000);
    add(8'b0_110_000_0, 2'b01, 4'b0000);
    add(8'b0_110_000_1, 2'b01, 4'b1000);
    add(8'b0_000_000_0, 2'b01, 4'b0000);
    add(8'b0_000_000_0, 2'b00, 4'b0000);
    // Reset, then simultaneous request and round-robin order 0,1,0,1.
    add(8'b1_000_000_0, 2'b00, 4'b0000);
    add(8'b0_110_110_0, 2'b00, 4'b0000);
    add(8'b0_110_110_0, 2'b01, 4'b0000);
    add(8'b0_110_110_1, 2'b01, 4'b1000);
    add(8'b0_000_110_0, 2'b01, 4'b0000);
    add(8'b0_000_110_0, 2'b00, 4'b0000);
    add(8'b0_000_111_0, 2'b10, 4'b0000);
    add(8'b0_000_111_1, 2'b10, 4'b0100);
    add(8'b0_110_000_0, 2'b10, 4'b0000);
    add(8'b0_110_110_0, 2'b00, 4'b0000);
    add(8'b0_110_110_0, 2'b01, 4'b0000);
    add(8'b0_110_110_1, 2'b01, 4'b1000);
    add(8'b0_000_110_0, 2'b01, 4'b0000);
    add(8'b0_110_110_0, 2'b00, 4'b0000);
    add(8'b0_110_110_0, 2'b10, 4'b0000);
    // Burst hold: three beats by m1 while m0 waits.
    add(8'b0_110_111_1, 2'b10, 4'b0100);
    add(8'b0_110_101_0, 2'b10, 4'b0000);
    add(8'b0_110_111_1, 2'b10, 4'b0100);
    add(8'b0_110_110_1, 2'b10, 4'b0100);
    add(8'b0_110_000_0, 2'b10, 4'b0000);
    add(8'b0_110_000_0, 2'b00, 4'b0000);
    add(8'b0_110_000_0, 2'b01, 4'b0000);
    add(8'b0_110_000_1, 2'b01, 4'b1000);
    add(8'b0_000_000_0, 2'b01, 4'b0000);
    add(8'b0_000_000_1, 2'b00, 4'b0000);
    // Reset in GRANT1; late ack and ack after cyc drop are dropped.
    add(8'b0_000_111_0, 2'b00, 4'b0000);
    add(8'b1_000_111_0, 2'b10, 4'b0000);
    add(8'b0_000_111_1, 2'b00, 4'b0000);
    add(8'b0_000_000_1, 2'b10, 4'b0000);
    add(8'b0_000_000_0, 2'b00, 4'b0000);
`ifdef WB_ARB_TIMEOUT_EN
    // m0 write with a hung slave, m1 pending.
    add(8'b0_111_110_0, 2'b00, 4'b0000);
    for (int i = 0; i < 8; i++) add(8'b0_111_110_0, 2'b01, 4'b0000);
    add(8'b0_111_110_0, 2'b01, 4'b0011);
    add(8'b0_111_110_1, 2'b01, 4'b0001);
    add(8'b0_000_110_0, 2'b01, 4'b0001);
    add(8'b0_000_110_0, 2'b00, 4'b0000);
    add(8'b0_000_110_0, 2'b10, 4'b0000);
    add(8'b0_000_000_0, 2'b10, 4'b0000);
    add(8'b0_000_000_0, 2'b00, 4'b0000);
`endif

    rst_i = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
    m0_addr_i = A0; m1_addr_i = A1; m0_data_i = D0; m1_data_i = D1; s_data_i = SD;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      {rst_i, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = vecs[i].in;
      sb.push_back(vecs[i]);
      #1;
      e    = sb.pop_front();
      own0 = (e.gnt == 2'b01) && !e.ex[0];
      own1 = (e.gnt == 2'b10) && !e.ex[0];
      r    = $sformatf("row%0d", i);
      chk({r, " gnt"},     {62'd0, gnt_o}, {62'd0, e.gnt});
      chk({r, " s_cyc"},   {63'd0, s_cyc_o}, {63'd0, own0 ? e.in[6] : own1 ? e.in[3] : 1'b0});
      chk({r, " s_stb"},   {63'd0, s_stb_o}, {63'd0, own0 ? e.in[5] : own1 ? e.in[2] : 1'b0});
      chk({r, " s_we"},    {63'd0, s_we_o},  {63'd0, own0 ? e.in[4] : own1 ? e.in[1] : 1'b0});
      chk({r, " s_addr"},  {32'd0, s_addr_o}, {32'd0, own0 ? A0 : own1 ? A1 : 32'd0});
      chk({r, " s_data"},  s_data_o, own0 ? D0 : own1 ? D1 : 64'd0);
      chk({r, " m0_ack"},  {63'd0, m0_ack_o}, {63'd0, e.ex[3]});
      chk({r, " m1_ack"},  {63'd0, m1_ack_o}, {63'd0, e.ex[2]});
      chk({r, " m0_data"}, m0_data_o, own0 ? SD : 64'd0);
      chk({r, " m1_data"}, m1_data_o, own1 ? SD : 64'd0);
      chk({r, " m0_err"},  {63'd0, m0_err_o}, {63'd0, e.ex[1]});
      chk({r, " m1_err"},  {63'd0, m1_err_o}, 64'd0);
    end

    @(negedge clk_i);
    {rst_i, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
    xact(64'hDEAD_BEEF_0000_0001, 0);
    xact(64'h0123_4567_89AB_CDEF, 1);
    xact(64'hFFFF_0000_FFFF_0000, 2);

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
